// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, access sizes and FSM states for the MEM stage
package mem_access_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int BE_W = 4;
  localparam logic ENABLED_ = 1'b0;
  localparam logic DISABLED = 1'b0;
  typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10} mem_size_t;
  typedef enum logic [1:0] {MA_IDLE, MA_BUSY, MA_DONE} ma_state_t;
endpackage

// File: rtl/mem_access_load_align.sv
// load_align: picks the addressed byte/half lane out of a bus word and sign/zero-extends it
module load_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [1:0]        off,
  output logic [DATA_W-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[8*off +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    data = size[1] ? rdata : size[0] ? {{16{sign & h[15]}}, h} : {{24{sign & b[7]}}, b};
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store controller driving the data bus and the MEM/WB inputs
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  valid_mem,
  input  logic                  mem_read_mem,
  input  logic                  mem_write_mem,
  input  logic [1:0]            mem_size_mem,
  input  logic                  mem_signed_mem,
  input  logic [DATA_W-1:0]     alu_result_mem,
  input  logic [DATA_W-1:0]     store_data_mem,
  input  logic [REG_ADDR_W-1:0] dst_addr_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [BE_W-1:0]       bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  stall,
  output logic                  misalign,
  output logic                  bus_err,
  output logic [DATA_W-1:0]     addr_mem,
  output logic [DATA_W-1:0]     dout_mem,
  output logic [REG_ADDR_W-1:0] dst_addr_mem,
  output logic                  mem_to_reg_mem,
  output logic                  reg_write_mem
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  ma_state_t state, state_nxt;
  logic [7:0] cnt;
  logic err_q, we_q, idle, busy, done;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0] be_q, be;
  logic [DATA_W-1:0] wdata_q, rdata_q, wdata, ld_data;
  logic [1:0] off;
  logic mem_op, mis, start, timeout;
  assign off = alu_result_mem[1:0];
  assign mem_op = valid_mem & (mem_read_mem | mem_write_mem);
  assign mis = mem_op & (mem_size_mem[1] ? |off : mem_size_mem[0] & off[0]);
  assign start = mem_op & ~mis;
  assign timeout = cnt == TO_LAST;
  assign be = mem_size_mem[1] ? 4'hf : mem_size_mem[0] ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
  assign wdata = mem_size_mem[1] ? store_data_mem :
                 mem_size_mem[0] ? {2{store_data_mem[15:0]}} : {4{store_data_mem[7:0]}};
  assign addr_mem = alu_result_mem;
  assign dst_addr_mem = dst_addr_in;
  assign mem_to_reg_mem = mem_to_reg_in;
  // size/sign/offset come straight from the inputs, which upstream holds stable while stalled
  load_align u_align (
    .rdata(bus_rdata),
    .size (mem_size_mem),
    .sign (mem_signed_mem),
    .off  (off),
    .data (ld_data)
  );
  always_ff @(posedge clk)
    if (reset_ == ENABLED_) begin
      state <= MA_IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      rdata_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= busy ? cnt + 8'd1 : '0;
      if (idle && start) begin
        addr_q <= {alu_result_mem[ADDR_W-1:2], 2'b00};
        be_q <= be;
        wdata_q <= wdata;
        we_q <= mem_write_mem;
        err_q <= 1'b0;
      end
      if (busy && (bus_ack || timeout)) begin
        rdata_q <= (bus_ack && !we_q) ? ld_data : '0;
        err_q <= ~bus_ack;
      end
    end
  always_comb begin
    idle = state == MA_IDLE;
    busy = state == MA_BUSY;
    done = state == MA_DONE;
    state_nxt = idle ? (start ? MA_BUSY : MA_IDLE) : busy ? ((bus_ack || timeout) ? MA_DONE : MA_BUSY) : MA_IDLE;
    bus_req = busy;
    bus_we = busy & we_q;
    bus_addr = busy ? addr_q : '0;
    bus_be = busy ? be_q : '0;
    bus_wdata = busy ? wdata_q : '0;
    stall = (idle & start) | busy;
    misalign = idle & mis;
    bus_err = done & err_q;
    dout_mem = done ? rdata_q : '0;
    reg_write_mem = reg_write_in & ~misalign & ~bus_err;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: per-instruction timeline model of the MEM stage checked every cycle, plus pinned cases
module tb_mem_access;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset_, valid_mem, mem_read_mem, mem_write_mem, mem_signed_mem;
  logic [1:0] mem_size_mem;
  logic [31:0] alu_result_mem, store_data_mem, bus_rdata;
  logic [4:0] dst_addr_in;
  logic mem_to_reg_in, reg_write_in, bus_ack;
  logic bus_req, bus_we, stall, misalign, bus_err, mem_to_reg_mem, reg_write_mem;
  logic [31:0] bus_addr, bus_wdata, addr_mem, dout_mem;
  logic [3:0] bus_be;
  logic [4:0] dst_addr_mem;
  int checks = 0, errors = 0;
  logic chk = 1'b0;
  logic e_stall, e_req, e_mis, e_err, e_rw, e_we, e_dchk;
  logic [31:0] e_addr, e_wdata, e_dout;
  logic [3:0] e_be;
  int n_stall = 0, n_req = 0, n_err = 0, n_mis = 0;
  logic [31:0] l_addr, l_wdata, l_dout;
  logic [3:0] l_be;
  logic l_we, l_rw;

  mem_access #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_(reset_), .valid_mem(valid_mem), .mem_read_mem(mem_read_mem),
    .mem_write_mem(mem_write_mem), .mem_size_mem(mem_size_mem), .mem_signed_mem(mem_signed_mem),
    .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem), .dst_addr_in(dst_addr_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .stall(stall), .misalign(misalign), .bus_err(bus_err), .addr_mem(addr_mem),
    .dout_mem(dout_mem), .dst_addr_mem(dst_addr_mem), .mem_to_reg_mem(mem_to_reg_mem),
    .reg_write_mem(reg_write_mem)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [1:0] sz, input logic sg, input logic [1:0] off);
    logic [31:0] s;
    s = d >> (8 * off);
    if (sz == 2'b00) return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
    if (sz == 2'b01) return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
    return d;
  endfunction

  always @(negedge clk) if (chk) begin
    cmp("stall", 32'(stall), 32'(e_stall));
    cmp("bus_req", 32'(bus_req), 32'(e_req));
    cmp("misalign", 32'(misalign), 32'(e_mis));
    cmp("bus_err", 32'(bus_err), 32'(e_err));
    cmp("reg_write_mem", 32'(reg_write_mem), 32'(e_rw));
    cmp("addr_mem", addr_mem, alu_result_mem);
    cmp("dst_addr_mem", 32'(dst_addr_mem), 32'(dst_addr_in));
    cmp("mem_to_reg_mem", 32'(mem_to_reg_mem), 32'(mem_to_reg_in));
    if (e_req) begin
      cmp("bus_we", 32'(bus_we), 32'(e_we));
      cmp("bus_addr", bus_addr, e_addr);
      cmp("bus_be", 32'(bus_be), 32'(e_be));
      cmp("bus_wdata", bus_wdata, e_wdata);
    end
    if (e_dchk) cmp("dout_mem", dout_mem, e_dout);
    if (stall) n_stall++;
    if (bus_err) n_err++;
    if (misalign) n_mis++;
    if (bus_req) begin
      n_req++;
      l_addr = bus_addr;
      l_be = bus_be;
      l_wdata = bus_wdata;
      l_we = bus_we;
    end
    l_dout = dout_mem;
    l_rw = reg_write_mem;
  end

  // k = BUSY cycle carrying the ack (1..TO), 0 = slave never answers
  task automatic run_op(input logic v, rd, wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, sd, input logic [4:0] dst, input logic m2r, rw,
                        input int k, input logic [31:0] rdata,
                        output int d_stall, d_req, d_err, d_mis);
    logic mem, mis, busy;
    int ackc, len, s0, r0, e0, m0;
    mem = v & (rd | wr);
    mis = mem & ((sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]));
    ackc = (k == 0) ? TO : k;
    len = (!mem || mis) ? 1 : ackc + 2;
    s0 = n_stall; r0 = n_req; e0 = n_err; m0 = n_mis;
    valid_mem = v; mem_read_mem = rd; mem_write_mem = wr; mem_size_mem = sz; mem_signed_mem = sg;
    alu_result_mem = a; store_data_mem = sd; dst_addr_in = dst; mem_to_reg_in = m2r; reg_write_in = rw;
    e_we = wr;
    e_addr = {a[31:2], 2'b00};
    e_be = (sz == 2'b00) ? 4'(1 << a[1:0]) : (sz == 2'b01) ? 4'(3 << a[1:0]) : 4'hf;
    e_wdata = (sz == 2'b00) ? {4{sd[7:0]}} : (sz == 2'b01) ? {2{sd[15:0]}} : sd;
    e_dout = wr ? 32'h0 : ld_model(rdata, sz, sg, a[1:0]);
    for (int c = 0; c < len; c++) begin
      busy = mem && !mis && c >= 1 && c <= ackc;
      bus_ack = busy ? (k != 0 && c == k) : (c == 0 || c == len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_rdata = (busy && bus_ack) ? rdata : $urandom;
      e_stall = mem && !mis && c <= ackc;
      e_req = busy;
      e_mis = mis;
      e_err = mem && !mis && k == 0 && c == len - 1;
      e_rw = rw && !mis && !e_err;
      e_dchk = mem && !mis && k != 0 && c == len - 1;
      chk = 1'b1;
      @(posedge clk); #1;
    end
    chk = 1'b0;
    bus_ack = 1'b0;
    d_stall = n_stall - s0; d_req = n_req - r0; d_err = n_err - e0; d_mis = n_mis - m0;
  endtask

  initial begin
    int ds, dr, de, dm, kind, k;
    logic [31:0] a;
    logic [1:0] sz;
    reset_ = 1'b0; valid_mem = 1'b0; mem_read_mem = 1'b0; mem_write_mem = 1'b0; mem_size_mem = 2'b00;
    mem_signed_mem = 1'b0; alu_result_mem = 32'h1234; store_data_mem = 32'h0; dst_addr_in = 5'd0;
    mem_to_reg_in = 1'b0; reg_write_in = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_ = 1'b1;
    @(posedge clk); #1;
    cmp("rst_addr_mem", addr_mem, 32'h1234);
    cmp("rst_stall", 32'(stall), 32'h0);
    cmp("rst_bus_req", 32'(bus_req), 32'h0);
    cmp("rst_bus_be", 32'(bus_be), 32'h0);
    cmp("rst_bus_addr", bus_addr, 32'h0);
    cmp("rst_dout_mem", dout_mem, 32'h0);
    cmp("rst_bus_err", 32'(bus_err), 32'h0);
    run_op(1, 1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd3, 1, 1, 1, 32'h80FFFFFF, ds, dr, de, dm);
    cmp("lb_be", 32'(l_be), 32'h8);
    cmp("lb_addr", l_addr, 32'h100);
    cmp("lb_stall_cycles", 32'(ds), 32'd2);
    cmp("lb_dout", l_dout, 32'hFFFFFF80);
    run_op(1, 0, 1, 2'b01, 0, 32'h202, 32'h0000BEEF, 5'd0, 0, 0, 4, 32'h0, ds, dr, de, dm);
    cmp("sh_we", 32'(l_we), 32'h1);
    cmp("sh_be", 32'(l_be), 32'hC);
    cmp("sh_wdata", l_wdata, 32'hBEEFBEEF);
    cmp("sh_stall_cycles", 32'(ds), 32'd5);
    run_op(1, 1, 0, 2'b10, 0, 32'h301, 32'h0, 5'd4, 1, 1, 1, 32'h0, ds, dr, de, dm);
    cmp("mis_req_cycles", 32'(dr), 32'd0);
    cmp("mis_pulses", 32'(dm), 32'd1);
    cmp("mis_reg_write", 32'(l_rw), 32'h0);
    run_op(1, 1, 0, 2'b10, 0, 32'h500, 32'h0, 5'd5, 1, 1, 0, 32'h0, ds, dr, de, dm);
    cmp("to_req_cycles", 32'(dr), 32'd4);
    cmp("to_err_pulses", 32'(de), 32'd1);
    cmp("to_reg_write", 32'(l_rw), 32'h0);
    valid_mem = 1'b1; mem_read_mem = 1'b1; mem_write_mem = 1'b0; mem_size_mem = 2'b10;
    alu_result_mem = 32'h400; bus_ack = 1'b0;
    @(posedge clk); #1;
    cmp("rb_bus_req", 32'(bus_req), 32'h1);
    reset_ = 1'b0; valid_mem = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    cmp("rb_req_after", 32'(bus_req), 32'h0);
    cmp("rb_stall_after", 32'(stall), 32'h0);
    run_op(1, 1, 0, 2'b10, 0, 32'h404, 32'h0, 5'd6, 1, 1, 2, 32'hCAFEF00D, ds, dr, de, dm);
    cmp("rb_lw_dout", l_dout, 32'hCAFEF00D);
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sz = 2'($urandom_range(0, 2));
      k = $urandom_range(0, TO);
      run_op(1'($urandom_range(0, 7) != 0), kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)),
             a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             k, $urandom, ds, dr, de, dm);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

MEM-stage load/store controller for the five-stage MIPS pipeline. It is the producer side of the MEM/WB pipeline register: it drives the address, load data, destination register and write-back controls that MEM/WB captures. For memory instructions it runs a req/ack transaction on the data bus, aligns and extends load data, and stalls the pipeline until the transaction completes. Non-memory instructions pass straight through.

## Interface
- `TIMEOUT_CYC`, default 255: maximum number of BUSY cycles without `bus_ack` before the access is aborted.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset_` in 1: synchronous reset, active-low (`ENABLED_`).
- `valid_mem` in 1: an instruction is present in MEM.
- `mem_read_mem` in 1: the instruction is a load.
- `mem_write_mem` in 1: the instruction is a store.
- `mem_size_mem` in 2: access size; `MEM_BYTE`=00, `MEM_HALF`=01, `MEM_WORD`=10.
- `mem_signed_mem` in 1: sign-extend load data (LB/LH); 0 means zero-extend.
- `alu_result_mem` in `DataBus`: effective address, or ALU result for non-memory instructions.
- `store_data_mem` in `DataBus`: rt value for stores.
- `dst_addr_in` in `RegAddrBus`: destination register.
- `mem_to_reg_in` in 1: write-back selects memory data.
- `reg_write_in` in 1: instruction writes the register file.
- `bus_req` out 1: request to the data bus.
- `bus_we` out 1: request is a write.
- `bus_addr` out `AddrBus`: word-aligned address (bits [1:0] are 0).
- `bus_be` out 4: byte enables.
- `bus_wdata` out `DataBus`: write data.
- `bus_rdata` in `DataBus`: read data, valid in the `bus_ack` cycle.
- `bus_ack` in 1: transaction complete.
- `stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `misalign` out 1: address exception pulse.
- `bus_err` out 1: timeout pulse.
- `addr_mem` out `DataBus`: to MEM/WB.
- `dout_mem` out `DataBus`: to MEM/WB.
- `dst_addr_mem` out `RegAddrBus`: to MEM/WB.
- `mem_to_reg_mem` out 1: to MEM/WB.
- `reg_write_mem` out 1: to MEM/WB.

## Operation
- A memory instruction is `valid_mem & (mem_read_mem | mem_write_mem)`.
- Lanes are little-endian: byte offset n = `alu_result_mem[1:0]` maps to lane n.
  - Byte access: `bus_be = 1<<n`, the store byte is replicated to all 4 lanes.
  - Half access: `bus_be` = 0011 or 1100, the store halfword is replicated to both halves.
  - Word access: `bus_be` = 1111.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus request is made.
  - `misalign`=1 for that cycle, `reg_write_mem`=0, `stall`=0.
- FSM states:
  - IDLE: a non-memory or misaligned instruction passes through combinationally. An aligned memory instruction sets `stall`=1, registers the address, be and wdata, and moves to BUSY.
  - BUSY: `bus_req`=1 with stable address, be, we and wdata; `stall`=1. The 8-bit wait counter increments each cycle.
    - On `bus_ack`: capture the aligned/extended load data into `rdata_q` and move to DONE.
    - When the counter reaches `TIMEOUT_CYC` without an ack: set `err_q` and move to DONE.
  - DONE: `stall`=0 and `dout_mem`=`rdata_q`. If `err_q` is set, `bus_err`=1 and `reg_write_mem`=0. The counter clears and the FSM returns to IDLE.
- `bus_ack` is ignored outside BUSY.
- Upstream holds all `*_mem` inputs stable while `stall`=1.
- Reset: the FSM goes to IDLE, the counter and `err_q` clear, `rdata_q`=0, `bus_req` deasserts at that edge. The bus slave must tolerate an abandoned request.

## Timing
- Reset values: `bus_req`, `bus_we`, `stall`, `misalign` and `bus_err` = 0; `bus_be` = 0; `bus_addr`, `bus_wdata` and `dout_mem` = 0; in IDLE, pass-through outputs follow their inputs.
- Pass-through instruction: 0 added cycles.
- Memory access with ack in the k-th BUSY cycle: `stall` is high for k+1 cycles (the IDLE detect cycle plus k BUSY cycles). MEM/WB captures the result at the end of the DONE cycle.
- Minimum memory op: 3 cycles (detect, BUSY+ack, DONE).
- Timeout: `bus_err` is asserted in the cycle after BUSY cycle `TIMEOUT_CYC`.
- Stores: `dout_mem` = 0 and `reg_write_mem` = `reg_write_in` (normally 0).

## Structure
- `defines.v` holds:
  - `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`
  - FSM state encodings `MA_IDLE`/`MA_BUSY`/`MA_DONE`
  - `BE_W`=4
  - the existing `DataBus`, `AddrBus`, `RegAddrBus`, `ENABLED_` and `DISABLED`
- Sub-module `load_align`: purely combinational. It extracts and sign/zero-extends `bus_rdata` from size, signed and offset. It is instantiated once.

## Test plan
- Reset release with `valid_mem`=0, ALU result 0x1234 → `addr_mem`=0x1234, `stall`=0, `bus_req`=0.
- LB, addr 0x103, signed, ack on first BUSY cycle, rdata 0x80FFFFFF → `bus_be`=1000, `bus_addr`=0x100, `stall` high for 2 cycles, `dout_mem`=0xFFFFFF80.
- SH, addr 0x202, data 0x0000BEEF, ack after 3 wait cycles → `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xBEEFBEEF, `stall` high for 5 cycles.
- LW at 0x301 → no `bus_req`, `misalign`=1 for 1 cycle, `reg_write_mem`=0.
- LW with no ack, `TIMEOUT_CYC`=4 → `bus_req` high for 4 cycles, then `bus_err`=1 for 1 cycle, `reg_write_mem`=0, FSM back to IDLE.
- `reset_`=0 during BUSY → `bus_req`=0 and `stall`=0 after that edge; a subsequent LW completes normally.
